// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing helper shared by uart_tx / uart_rx.
package uart_pkg;

  // FSM state encoding, also exposed on the debug port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per line bit (integer division, truncating)
  function automatic int cyc_per_bit(input int sys_clk, input int baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle (high) line is seen immediately after reset.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Two back-to-back flops to settle metastability on the async input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and framing-error strobe.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [1:0] state_out_dbg
);

  localparam int CYC_COUNT  = cyc_per_bit(SYSTEM_CLOCK, BAUD_RATE);
  localparam int HALF_COUNT = CYC_COUNT / 2;
  localparam int CW         = $clog2(CYC_COUNT);

  localparam logic [CW-1:0] C_LAST = CW'(CYC_COUNT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_COUNT - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // Index of the last DATA-state sample (parity bit is a 9th sample)
`ifdef UART_RX_PARITY_EN
  localparam logic [3:0] B_LAST = 4'd8;
`else
  localparam logic [3:0] B_LAST = 4'd7;
`endif

  logic        w_din_s;
  uart_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_armed;
`ifdef UART_RX_PARITY_EN
  logic        r_par;
  logic        r_perr;
`endif

  uart_rx_sync u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (din),
    .o_q   (w_din_s)
  );

  // Frame recovery FSM: counters, shift register and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // After a break the line must go high again before we re-arm
          if (r_armed && !w_din_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end else if (!r_armed && w_din_s) begin
            r_armed <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (!w_din_s) begin
              r_state <= DATA;
              r_bit   <= '0;
            end else begin
              r_state <= IDLE;  // glitch: too short to be a start bit
            end
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            r_bit <= r_bit + 4'd1;
`ifdef UART_RX_PARITY_EN
            if (r_bit == 4'd8) r_par <= w_din_s;
            else
`endif
            r_shift <= {w_din_s, r_shift[7:1]};
            if (r_bit == B_LAST) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (w_din_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_perr  <= ^{r_shift, r_par};
`endif
            end else begin
              r_ferr  <= 1'b1;
              r_armed <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out      = r_data;
  assign valid         = r_valid;
  assign frame_err     = r_ferr;
  assign state_out_dbg = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err    = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bit-banged frames against uart_rx.
// Scaled timing: 160 Hz / 10 baud -> 16 cycles per bit, half = 8.
module tb_uart_rx;

  localparam int SYS = 160;
  localparam int BAUD = 10;
  localparam int CYC = SYS / BAUD;
  localparam int HALF = CYC / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic [1:0] state_out_dbg;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         pcnt = 0;
`endif

  uart_rx #(.SYSTEM_CLOCK(SYS), .BAUD_RATE(BAUD)) dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .data_out      (data_out),
    .valid         (valid),
    .frame_err     (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err    (parity_err),
`endif
    .state_out_dbg (state_out_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vcnt = 0;
  int fcnt = 0;
  int bad = 0;
  int last_vcyc = 0;
  logic [7:0] vlog[$];
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vlog.push_back(data_out);
      last_vcyc = cyc;
    end
    if (frame_err) fcnt++;
    if (valid && frame_err) bad++;
    if ((valid && prev_v) || (frame_err && prev_f)) bad++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin
      pcnt++;
      if (!valid) bad++;
    end
`endif
    prev_v = valid;
    prev_f = frame_err;
  end

  task automatic drive_bit(input logic b);
    din = b;
    repeat (CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state_out_dbg == s) return;
      @(negedge clk);
    end
  endtask

  initial begin
    int t0;
    int v0;
    int busy;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    chk("rst_state", {30'd0, state_out_dbg}, 32'h0);
    rst = 1'b0;
    repeat (2 * CYC) @(negedge clk);

    // Single frame A3 plus latency from start-bit edge to valid
    t0 = cyc;
    send_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    chk("a3_vcnt", vcnt, 1);
    chk("a3_data", {24'd0, data_out}, 32'hA3);
    chk("a3_latency", last_vcyc - t0, 2 + HALF + 9 * CYC + 1);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_vcnt", vcnt, 3);
    chk("b2b_d1", {24'd0, vlog[1]}, 32'h00);
    chk("b2b_d2", {24'd0, vlog[2]}, 32'hFF);
    chk("b2b_state", {30'd0, state_out_dbg}, 32'h0);

    // Glitch shorter than half a bit
    din = 1'b0;
    repeat (5) @(negedge clk);
    din = 1'b1;
    wait_state(2'd1, 10);
    chk("glitch_start", {30'd0, state_out_dbg}, 32'h1);
    wait_state(2'd0, 20);
    chk("glitch_idle", {30'd0, state_out_dbg}, 32'h0);
    repeat (2 * CYC) @(negedge clk);
    chk("glitch_vcnt", vcnt, 3);
    chk("glitch_fcnt", fcnt, 0);

    // Framing error followed by a held-low break
    send_frame(8'h0F, 1'b0);
    busy = 0;
    for (int i = 0; i < 5 * 10 * CYC; i++) begin
      if (state_out_dbg != 2'd0) busy++;
      @(negedge clk);
    end
    chk("ferr_fcnt", fcnt, 1);
    chk("ferr_vcnt", vcnt, 3);
    chk("ferr_hold", {24'd0, data_out}, 32'hFF);
    chk("break_quiet", busy, 0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_break_vcnt", vcnt, 4);
    chk("post_break_data", {24'd0, data_out}, 32'h3C);

    // Reset mid-frame, then a clean frame
    v0 = vcnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("mid_state", {30'd0, state_out_dbg}, 32'h2);
    #1 rst = 1'b1;
    din = 1'b1;
    #1;
    chk("async_state", {30'd0, state_out_dbg}, 32'h0);
    chk("async_data", {24'd0, data_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * CYC) @(negedge clk);
    chk("mid_no_valid", vcnt, v0);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_rx_vcnt", vcnt, v0 + 1);
    chk("rst_rx_data", {24'd0, data_out}, 32'h3C);

`ifdef UART_RX_PARITY_EN
    // 07 has three ones: parity bit 0 gives odd total -> parity_err
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_bad_perr", pcnt, 1);
    chk("par_bad_data", {24'd0, data_out}, 32'h07);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_ok_perr", pcnt, 1);
    chk("par_ok_vcnt", vcnt, v0 + 3);
`endif

    chk("strobe_rules", bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
